// File: rtl/disp_scanout.sv
// disp_scanout: 640x480 VGA scan-out for a 64x32 CHIP-8 display. Each
// CHIP-8 pixel is shown as 10 clocks by 15 lines.
// During horizontal blanking it takes display-RAM port A from the CPU and
// reads the 8 bytes of the row shown on the next line. It then hands the
// port back to the CPU.
// Ports: clk, rst_n (async, active low); disp_ram_req/disp_ram_gnt for the
// CPU handshake; cpu_* in, ram_* out to the dual-port RAM; ram_qa holds read
// data one clock after the address; vga_* are registered video outputs;
// underrun is a sticky flag for an abandoned line fetch.
module disp_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int X_SCALE  = 10,
   parameter int Y_SCALE  = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       disp_ram_req,
   output logic       disp_ram_gnt,
   input  logic [7:0] cpu_aa,
   input  logic [7:0] cpu_ab,
   input  logic [7:0] cpu_da,
   input  logic [7:0] cpu_db,
   input  logic       cpu_wa,
   input  logic       cpu_wb,
   output logic [7:0] ram_aa,
   output logic [7:0] ram_ab,
   output logic [7:0] ram_da,
   output logic [7:0] ram_db,
   output logic       ram_wa,
   output logic       ram_wb,
   input  logic [7:0] ram_qa,
   output logic       vga_hs_n,
   output logic       vga_vs_n,
   output logic       vga_blank_n,
   output logic       vga_pix,
   output logic       underrun
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
   localparam logic [9:0] H_DEC   = 10'(H_ACTIVE - 1);
   localparam logic [9:0] H_ABORT = 10'(H_TOTAL - 10);
   localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
   localparam logic [9:0] V_ACT1  = 10'(V_ACTIVE - 1);
   localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0] X_LAST  = 4'(X_SCALE - 1);
   localparam logic [3:0] Y_LAST  = 4'(Y_SCALE - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FETCH,
      DRAIN
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [9:0]       hcnt;
   logic [9:0]       vcnt;
   logic [3:0]       xsub;
   logic [5:0]       col;
   logic [3:0]       ysub;
   logic [4:0]       row;
   logic [4:0]       next_row;
   logic [4:0]       frow;
   logic [2:0]       k;
   logic             cap_en;
   logic [2:0]       cap_k;
   logic [7:0][7:0]  shadow;
   logic [63:0]      disp_line;
   logic             done;
   logic             due;
   logic             start;
   logic             abort;
   logic             vis;

   // Raster counters; sub-counters track the CHIP-8 pixel/row under the beam.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
         vcnt <= '0;
         xsub <= '0;
         col  <= '0;
         ysub <= '0;
         row  <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         xsub <= '0;
         col  <= '0;
         if (vcnt == V_LAST) begin
            vcnt <= '0;
            ysub <= '0;
            row  <= '0;
         end else begin
            vcnt <= vcnt + 10'd1;
            if (ysub == Y_LAST) begin
               ysub <= '0;
               row  <= row + 5'd1;
            end else begin
               ysub <= ysub + 4'd1;
            end
         end
      end else begin
         hcnt <= hcnt + 10'd1;
         if (hcnt < H_ACT) begin
            if (xsub == X_LAST) begin
               xsub <= '0;
               col  <= col + 6'd1;
            end else begin
               xsub <= xsub + 4'd1;
            end
         end
      end
   end

   // Row and fetch flag for the line after this one. The last line of the
   // frame preloads row 0.
   assign next_row = (vcnt == V_LAST) ? 5'd0 :
                     (ysub == Y_LAST) ? row + 5'd1 : row;
   assign due      = (vcnt == V_LAST) || (vcnt < V_ACT1);

   // Decide one clock early so that the first fetch address is on the bus
   // exactly at hcnt == H_ACTIVE when the CPU is not asking for the RAM.
   always_comb begin
      state_n = state;
      start   = 1'b0;
      abort   = 1'b0;
      unique case (state)
         IDLE: begin
            if (hcnt == H_DEC && due) begin
               start   = 1'b1;
               state_n = disp_ram_req ? WAIT : FETCH;
            end
         end
         WAIT: begin
            if (hcnt == H_ABORT) begin
               abort   = 1'b1;
               state_n = IDLE;
            end else if (!disp_ram_req) begin
               state_n = FETCH;
            end
         end
         FETCH: begin
            if (k == 3'd7) state_n = DRAIN;
         end
         DRAIN: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         k      <= '0;
         frow   <= '0;
         cap_en <= 1'b0;
         cap_k  <= '0;
      end else begin
         state  <= state_n;
         k      <= (state == FETCH) ? k + 3'd1 : 3'd0;
         cap_en <= (state == FETCH);
         cap_k  <= k;
         if (start) frow <= next_row;
      end
   end

   // Bytes land one clock after their address. The visible line only changes
   // at the end of a line whose fetch completed, so an abort repeats the old one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow    <= '0;
         disp_line <= '0;
         done      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (cap_en) shadow[3'd7 - cap_k] <= ram_qa;
         if (hcnt == H_LAST) begin
            done <= 1'b0;
            if (done) disp_line <= shadow;
         end else if (state == DRAIN) begin
            done <= 1'b1;
         end
         if (abort) underrun <= 1'b1;
      end
   end

   assign vis = (hcnt < H_ACT) && (vcnt < V_ACT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_hs_n    <= 1'b1;
         vga_vs_n    <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_pix     <= 1'b0;
      end else begin
         vga_hs_n    <= !(hcnt >= HS_BEG && hcnt < HS_END);
         vga_vs_n    <= !(vcnt >= VS_BEG && vcnt < VS_END);
         vga_blank_n <= vis;
         vga_pix     <= vis && disp_line[6'd63 - col];
      end
   end

   assign disp_ram_gnt = !(state == FETCH || state == DRAIN);

   assign ram_aa = disp_ram_gnt ? cpu_aa : {frow, k};
   assign ram_da = cpu_da;
   assign ram_wa = disp_ram_gnt && cpu_wa;
   assign ram_ab = cpu_ab;
   assign ram_db = cpu_db;
   assign ram_wb = disp_ram_gnt && cpu_wb;

endmodule
